dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 (core load/store) and port 1 (debug/DMA loader).
//  Grants at most one access per cycle and drives the memory's address/data/write-enable inputs.
//  Routes the read result back to the granted port one cycle later.
//  Sits between the core datapath and DMem. The memory registers addr/data/we on clk and returns read data from the registered address.
// PARAMETERS
//  MAX_WAIT   default 8   cycles port 1 may stay pending-but-ungranted before it is forced to win (fixed-priority mode only)
//  WAIT_WIDTH default 4   width of the starvation counter; must hold MAX_WAIT
// PORTS
//  clk          in   1                     clock
//  rst          in   1                     reset, synchronous, active-low
//  req0/req1    in   1                     access request, held until granted
//  we0/we1      in   1                     1=write, 0=read
//  addr0/addr1  in   DataAddrPath          byte address
//  wdata0/wdata1 in  DataPath              write data
//  gnt0/gnt1    out  1                     request accepted this cycle (combinational)
//  rvalid0/rvalid1 out 1                   read data valid on rdata (one cycle after a read grant)
//  rdata0/rdata1 out DataPath              read data; both ports are driven from mem_rdata
//  mem_addr     out  DataAddrPath          to memory addr
//  mem_wdata    out  DataPath              to memory dataIn
//  mem_we       out  1                     to memory wrEnable
//  mem_rdata    in   DataPath              from memory dataOut
// BEHAVIOUR
//  - Reset (rst==0 at posedge): gnt0/gnt1 forced 0 combinationally while rst==0.
//    rvalid0/rvalid1=0; pending-read owner register cleared; starvation counter=0; last-grant pointer=port 1 (so port 0 wins first in RR mode).
//  - Grant: exactly one gnt when any req is high; none when no req is high. A grant completes the handshake in that cycle (req&gnt).
//  - Memory mux: mem_addr/mem_wdata/mem_we come from the granted port.
//    With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
//  - Read latency: read granted in cycle N, memory latches the address at edge N, mem_rdata is valid in cycle N+1.
//    rvalidX=1 for exactly cycle N+1 (owner register), then 0.
//  - Writes never raise rvalid.
//  - Back-to-back: a new grant is allowed every cycle, including in the cycle an rvalid is returned.
//  - Same-address write (cycle N) then read (cycle N+1) returns the NEW data in N+2. This follows the memory's write-at-next-edge timing; no bypass.
//  - Fixed priority (default): port 0 wins ties.
//    Starvation counter increments each cycle req1&!gnt1 and saturates at MAX_WAIT. It clears on gnt1 or when req1 drops.
//    When the counter reaches MAX_WAIT, port 1 wins the next tie.
//  - Reset mid-operation: a pending rvalid is dropped (not delivered). The requester must reissue.
// CONFIGURATION
//  DMEM_ARB_ROUND_ROBIN_EN defined: ties go to the port not granted most recently (last-grant pointer updates on every grant).
//    The starvation counter and MAX_WAIT are unused; the counter is held at 0.
//  Not defined: fixed priority with starvation guard as above. The last-grant pointer is still kept but does not affect arbitration.
// STRUCTURE
//  Shared package (Types): DataPath, DataAddrPath (existing).
//    Add DMemArbPort enum {DMEM_PORT_CORE=0, DMEM_PORT_DBG=1}.
//    Add typedef struct DMemReq {req, we, addr, wdata}.
//  Sub-module: dmem_arb_pick. Combinational tie-break from {req0, req1, lastGrant, starved} -> one-hot grant. Kept separate so it can be unit-tested.
//  Top holds the owner register, the starvation counter, the last-grant pointer and the memory mux.
// TESTING
//  1. Only port 0 read addr 0x10 (mem holds 0xCAFE0001) -> gnt0 same cycle, rvalid0=1 with rdata0=0xCAFE0001 next cycle, rvalid1 stays 0.
//  2. Port 1 write addr 0x20 data 0x12345678, then port 1 read 0x20 next cycle -> rvalid1 two cycles after the write grant, rdata1=0x12345678.
//  3. Both req held continuously, fixed mode, MAX_WAIT=8 -> port 0 granted 8 cycles, then port 1 granted once, pattern repeats.
//  4. Same as 3 with DMEM_ARB_ROUND_ROBIN_EN -> grants strictly alternate 0,1,0,1; the first grant goes to port 0 after reset.
//  5. Read grant in cycle N, rst=0 in cycle N+1 -> rvalid0/rvalid1=0 in N+1 and N+2; mem_we=0 throughout reset.
//  6. No requests for 5 cycles -> gnt0/gnt1, rvalid*, mem_we all 0; mem_addr=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
//  Module   : dmem_arbiter_pkg
//  Brief    : Shared data-memory types and the request record used by the
//             data-memory arbiter and its tie-break helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  // Data word and byte-address widths used across the datapath.
  typedef logic [31:0] DataPath;
  typedef logic [31:0] DataAddrPath;

  // Requester identity, also the encoding of the last-grant pointer.
  typedef enum logic {
    DMEM_PORT_CORE = 1'b0,
    DMEM_PORT_DBG  = 1'b1
  } DMemArbPort;

  // One requester's view of a memory access.
  typedef struct packed {
    logic        req;
    logic        we;
    DataAddrPath addr;
    DataPath     wdata;
  } DMemReq;

  // Value presented to the memory when nobody is granted.
  localparam DMemReq c_idleReq = '0;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
// ============================================================================
//  Module   : dmem_arb_pick
//  Brief    : Combinational tie-break for the two data-memory requesters.
//             Produces a one-hot grant {port1, port0} from the requests, the
//             last-grant pointer and the starvation flag.
//             Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin ties.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  DMemArbPort i_lastGrant,
  input  logic       i_starved,
  output logic [1:0] o_grant
);

  logic w_dbgWinsTie;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Round-robin: the port that was not granted most recently wins a tie.
  logic w_unusedStarved;
  assign w_unusedStarved = i_starved;
  assign w_dbgWinsTie    = (i_lastGrant == DMEM_PORT_CORE);
`else
  // Fixed priority: core wins ties unless the debug port has been starved.
  logic w_unusedLastGrant;
  assign w_unusedLastGrant = i_lastGrant;
  assign w_dbgWinsTie      = i_starved;
`endif

  // One-hot grant: a lone requester always wins, a tie uses the rule above.
  always_comb begin
    o_grant = 2'b00;
    if (i_req0 && i_req1) begin
      o_grant = w_dbgWinsTie ? 2'b10 : 2'b01;
    end else if (i_req0) begin
      o_grant = 2'b01;
    end else if (i_req1) begin
      o_grant = 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Shares the single-port data memory between the core (port 0)
//             and the debug/DMA loader (port 1). One access per cycle; read
//             data is returned to the granted port one cycle after the grant.
//             Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin ties
//             instead of fixed priority with a starvation guard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT   = 8,
  parameter int WAIT_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  DataAddrPath addr0,
  input  DataAddrPath addr1,
  input  DataPath     wdata0,
  input  DataPath     wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output DataPath     rdata0,
  output DataPath     rdata1,
  output DataAddrPath mem_addr,
  output DataPath     mem_wdata,
  output logic        mem_we,
  input  DataPath     mem_rdata
);

  localparam logic [WAIT_WIDTH-1:0] c_maxWait = WAIT_WIDTH'(MAX_WAIT);

  DMemReq                w_port0;
  DMemReq                w_port1;
  DMemReq                w_granted;
  logic [1:0]            w_pick;
  logic                  w_starved;
  logic                  w_unusedReq;
  logic [1:0]            r_rdOwner;    // one-hot owner of the read in flight
  DMemArbPort            r_lastGrant;
  logic [WAIT_WIDTH-1:0] r_waitCnt;

  assign w_port0 = '{req: req0, we: we0, addr: addr0, wdata: wdata0};
  assign w_port1 = '{req: req1, we: we1, addr: addr1, wdata: wdata1};

  assign w_starved = (r_waitCnt == c_maxWait);

  dmem_arb_pick u_pick (
    .i_req0      (req0),
    .i_req1      (req1),
    .i_lastGrant (r_lastGrant),
    .i_starved   (w_starved),
    .o_grant     (w_pick)
  );

  // Grants are suppressed while reset is asserted, so nothing reaches memory.
  assign gnt0 = rst & w_pick[0];
  assign gnt1 = rst & w_pick[1];

  // Steer the granted port's access onto the memory; idle drives all zeros.
  always_comb begin
    w_granted = c_idleReq;
    if (gnt0) begin
      w_granted = w_port0;
    end else if (gnt1) begin
      w_granted = w_port1;
    end
  end

  assign mem_addr    = w_granted.addr;
  assign mem_wdata   = w_granted.wdata;
  assign mem_we      = w_granted.we;
  assign w_unusedReq = w_granted.req;

  // Remember which port owns the read whose data returns next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdOwner <= 2'b00;
    end else begin
      r_rdOwner <= {gnt1 & ~we1, gnt0 & ~we0};
    end
  end

  // A reset in the return cycle drops the read result immediately.
  assign rvalid0 = rst & r_rdOwner[0];
  assign rvalid1 = rst & r_rdOwner[1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

  // Track the most recently granted port; after reset port 0 is favoured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lastGrant <= DMEM_PORT_DBG;
    end else if (gnt0) begin
      r_lastGrant <= DMEM_PORT_CORE;
    end else if (gnt1) begin
      r_lastGrant <= DMEM_PORT_DBG;
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Round-robin needs no starvation guard; the counter stays at zero.
  always_ff @(posedge clk) begin
    r_waitCnt <= '0;
  end
`else
  // Count cycles port 1 waits while asking; saturate so it wins the next tie.
  always_ff @(posedge clk) begin
    if (!rst || !req1 || gnt1) begin
      r_waitCnt <= '0;
    end else if (r_waitCnt != c_maxWait) begin
      r_waitCnt <= r_waitCnt + WAIT_WIDTH'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Brief    : Self-checking bench for dmem_arbiter with a memory model, an
//             arbitration reference model and directed stimulus.
//             Build option: DMEM_ARB_ROUND_ROBIN_EN must match the DUT build.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  DataAddrPath addr0 = '0, addr1 = '0;
  DataPath     wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  DataPath     rdata0, rdata1, mem_wdata, mem_rdata;
  DataAddrPath mem_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory environment: registers addr/data/we, reads from registered address.
  logic [31:0] memArr [0:63];
  logic [31:0] memAddrQ = '0;
  always @(posedge clk) begin
    if (mem_we) memArr[mem_addr[7:2]] = mem_wdata;
    memAddrQ = mem_addr;
  end
  assign mem_rdata = memArr[memAddrQ[7:2]];

  // Reference model state.
  int          mWait = 0;
  int          mLast = 1;
  bit          mPend0 = 1'b0, mPend1 = 1'b0;
  logic [31:0] mData0 = '0, mData1 = '0;
  logic [31:0] shadow [0:63];

  // Which port must be granted now (-1 = none), from the arbitration rules.
  function automatic int expGrant();
    if (!rst) return -1;
    if (req0 && !req1) return 0;
    if (req1 && !req0) return 1;
    if (!req0 && !req1) return -1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    return (mLast == 1) ? 0 : 1;
`else
    return (mWait >= MAX_WAIT) ? 1 : 0;
`endif
  endfunction

  // Advance the model at each clock edge.
  always @(posedge clk) begin : modelStep
    int g;
    g = expGrant();
    mPend0 = 1'b0;
    mPend1 = 1'b0;
    if (rst) begin
      if (g == 0 && !we0) begin mPend0 = 1'b1; mData0 = shadow[addr0[7:2]]; end
      if (g == 1 && !we1) begin mPend1 = 1'b1; mData1 = shadow[addr1[7:2]]; end
      if (g == 0 && we0) shadow[addr0[7:2]] = wdata0;
      if (g == 1 && we1) shadow[addr1[7:2]] = wdata1;
      if (g >= 0) mLast = g;
      if (req1 && g != 1) mWait = (mWait < MAX_WAIT) ? mWait + 1 : MAX_WAIT;
      else mWait = 0;
    end else begin
      mWait = 0;
      mLast = 1;
    end
  end

  // Compare every DUT output against the model, away from the active edge.
  always @(negedge clk) begin : compare
    int          g;
    logic        eWe;
    logic [31:0] eAddr, eWd;
    g = expGrant();
    eWe = 1'b0; eAddr = '0; eWd = '0;
    if (g == 0) begin eWe = we0; eAddr = addr0; eWd = wdata0; end
    if (g == 1) begin eWe = we1; eAddr = addr1; eWd = wdata1; end
    check("gnt0", {31'b0, gnt0}, {31'b0, g == 0});
    check("gnt1", {31'b0, gnt1}, {31'b0, g == 1});
    check("mem_we", {31'b0, mem_we}, {31'b0, eWe});
    check("mem_addr", mem_addr, eAddr);
    check("mem_wdata", mem_wdata, eWd);
    check("rvalid0", {31'b0, rvalid0}, {31'b0, mPend0 && rst});
    check("rvalid1", {31'b0, rvalid1}, {31'b0, mPend1 && rst});
    if (mPend0 && rst) check("rdata0", rdata0, mData0);
    if (mPend1 && rst) check("rdata1", rdata1, mData1);
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] seq;
  logic [17:0] expSeq;

  initial begin
    for (int i = 0; i < 64; i++) begin
      memArr[i] = 32'h1000_0000 + i;
      shadow[i] = 32'h1000_0000 + i;
    end
    memArr[4] = 32'hCAFE0001;
    shadow[4] = 32'hCAFE0001;

    // Reset, then idle.
    repeat (2) nextCycle();
    @(negedge clk);
    check("rst_gnt0", {31'b0, gnt0}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    nextCycle();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_mem_addr", mem_addr, 32'd0);
      check("idle_rvalid0", {31'b0, rvalid0}, 32'd0);
    end

    // Port 0 reads 0x10.
    nextCycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    check("t1_gnt0", {31'b0, gnt0}, 32'd1);
    nextCycle();
    req0 = 1'b0;
    @(negedge clk);
    check("t1_rvalid0", {31'b0, rvalid0}, 32'd1);
    check("t1_rdata0", rdata0, 32'hCAFE0001);
    check("t1_rvalid1", {31'b0, rvalid1}, 32'd0);

    // Port 1 writes 0x20 then reads it back.
    nextCycle();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678;
    nextCycle();
    we1 = 1'b0;
    nextCycle();
    req1 = 1'b0;
    @(negedge clk);
    check("t2_rvalid1", {31'b0, rvalid1}, 32'd1);
    check("t2_rdata1", rdata1, 32'h12345678);

    // Both ports held: record which port wins over 18 cycles.
    nextCycle();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h10; addr1 = 32'h20;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      seq[i] = gnt1;
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    expSeq = 18'h2AAAA;
`else
    expSeq = 18'h20100;
`endif
    check("t3_grant_pattern", {14'b0, seq}, {14'b0, expSeq});

    // Port 1 drops briefly mid-wait, then both compete again.
    nextCycle();
    req1 = 1'b0;
    nextCycle();
    req1 = 1'b1; we1 = 1'b1; wdata1 = 32'hA5A5_0000; addr1 = 32'h24;
    repeat (12) nextCycle();
    req0 = 1'b0; req1 = 1'b0;

    // Reset in the cycle a read result would return.
    nextCycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    check("t5_gnt0", {31'b0, gnt0}, 32'd1);
    nextCycle();
    req0 = 1'b0; rst = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t5_rvalid0_n1", {31'b0, rvalid0}, 32'd0);
    check("t5_mem_we_rst", {31'b0, mem_we}, 32'd0);
    check("t5_gnt1_rst", {31'b0, gnt1}, 32'd0);
    nextCycle();
    @(negedge clk);
    check("t5_rvalid0_n2", {31'b0, rvalid0}, 32'd0);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    check("t5_gnt1_after", {31'b0, gnt1}, 32'd1);
    nextCycle();
    req1 = 1'b0;

    // Mixed traffic checked by the model.
    for (int i = 0; i < 60; i++) begin
      nextCycle();
      req0   = 1'($urandom_range(0, 1));
      req1   = 1'($urandom_range(0, 1));
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      addr0  = 32'($urandom_range(0, 15)) << 2;
      addr1  = 32'($urandom_range(0, 15)) << 2;
      wdata0 = $urandom;
      wdata1 = $urandom;
    end
    nextCycle();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
